// File: rtl/fft_seq_control.sv
// fft_seq_control: steps one shared radix-2 DIF butterfly through every stage of an N-point FFT
module fft_seq_control #(
  parameter int LOG2N    = 5,
  parameter int STG_W    = 4,
  parameter int PIPE_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             issue_vld,
  output logic [STG_W-1:0] stage_num,
  output logic [LOG2N-2:0] bfly_idx,
  output logic             m0_s,
  output logic [1:0]       m1_s,
  output logic             m2_s,
  output logic             m3_s,
  output logic [LOG2N-2:0] tw_addr,
  output logic             stage_done,
  output logic             fft_done
);
  localparam int BW = LOG2N - 1;
  localparam logic [STG_W-1:0] S_LAST = STG_W'(LOG2N - 1);
  localparam logic [3:0] CNT_INIT = PIPE_LAT > 1 ? 4'(PIPE_LAT - 2) : 4'd0;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [STG_W-1:0] s, s_nx;
  logic [BW-1:0] b, b_nx, tw;
  logic [3:0] cnt, cnt_nx;
  logic sd_nx, fd_nx, s_last;
  always_comb begin
    state_nx = state;
    s_nx = s;
    b_nx = b;
    cnt_nx = cnt;
    sd_nx = 1'b0;
    fd_nx = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: if (!stall) begin
        b_nx = b + 1'b1;
        sd_nx = &b;
        if (&b) s_nx = s_last ? '0 : s + 1'b1;
        if (&b && s_last) begin
          state_nx = PIPE_LAT > 1 ? DRAIN : IDLE;
          fd_nx = PIPE_LAT <= 1;
          cnt_nx = CNT_INIT;
        end
      end
      DRAIN: begin
        state_nx = cnt == '0 ? IDLE : DRAIN;
        fd_nx = cnt == '0;
        cnt_nx = cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      s <= '0;
      b <= '0;
      cnt <= '0;
      stage_done <= 1'b0;
      fft_done <= 1'b0;
    end else begin
      state <= state_nx;
      s <= s_nx;
      b <= b_nx;
      cnt <= cnt_nx;
      stage_done <= sd_nx;
      fft_done <= fd_nx;
    end
  end
  // s and b are held at zero outside RUN, so the decode needs no state gating
  assign s_last = s == S_LAST;
  assign tw = b << s;
  assign busy = state != IDLE;
  assign issue_vld = state == RUN && !stall;
  assign stage_num = s;
  assign bfly_idx = b;
  assign m0_s = !s_last && tw[BW-1];
  assign m1_s = s == '0 ? 2'd0 : s_last ? 2'd2 : 2'd1;
  assign m2_s = s[0];
  assign m3_s = s_last;
  assign tw_addr = tw;
endmodule

// File: tb/tb_fft_seq_control.sv
// tb_fft_seq_control: directed checks of the FFT sequencer (LOG2N=5/PIPE_LAT=4 and LOG2N=3/PIPE_LAT=0)
module tb_fft_seq_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stall = 1'b0;
  logic busy, issue_vld, m0_s, m2_s, m3_s, stage_done, fft_done;
  logic [3:0] stage_num, bfly_idx, tw_addr;
  logic [1:0] m1_s;
  logic start_b = 1'b0, stall_b = 1'b0;
  logic busy_b, issue_vld_b, m0_s_b, m2_s_b, m3_s_b, stage_done_b, fft_done_b;
  logic [3:0] stage_num_b;
  logic [1:0] bfly_idx_b, tw_addr_b, m1_s_b;
  int checks = 0, failures = 0;
  int done_cyc, issues;

  fft_seq_control #(.LOG2N(5), .STG_W(4), .PIPE_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .busy(busy), .issue_vld(issue_vld),
    .stage_num(stage_num), .bfly_idx(bfly_idx), .m0_s(m0_s), .m1_s(m1_s), .m2_s(m2_s), .m3_s(m3_s),
    .tw_addr(tw_addr), .stage_done(stage_done), .fft_done(fft_done));

  fft_seq_control #(.LOG2N(3), .STG_W(4), .PIPE_LAT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stall(stall_b), .busy(busy_b), .issue_vld(issue_vld_b),
    .stage_num(stage_num_b), .bfly_idx(bfly_idx_b), .m0_s(m0_s_b), .m1_s(m1_s_b), .m2_s(m2_s_b), .m3_s(m3_s_b),
    .tw_addr(tw_addr_b), .stage_done(stage_done_b), .fft_done(fft_done_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_issue"}, issue_vld, 0);
    chk({tag, "_stage"}, stage_num, 0);
    chk({tag, "_bfly"}, bfly_idx, 0);
    chk({tag, "_sel"}, {m0_s, m1_s, m2_s, m3_s}, 0);
    chk({tag, "_tw"}, tw_addr, 0);
    chk({tag, "_sdone"}, stage_done, 0);
    chk({tag, "_fdone"}, fft_done, 0);
  endtask

  // Entered just after a falling edge; returns at the sample point of the fft_done cycle.
  task automatic run(input int stall_at, input int stall_len, input int inject_at, input int abort_at,
                     output int dcyc, output int n_iss);
    int st = 0;
    logic pe = 1'b0;
    dcyc = -1;
    n_iss = 0;
    start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (n_iss == abort_at) begin
        #1;
        chk("abort_stage", stage_num, 2);
        chk("abort_bfly", bfly_idx, 9);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk_zero("async_rst");
        return;
      end
      stall = n_iss == stall_at && st < stall_len;
      start = n_iss == inject_at;
      #1;
      if (c == 1) begin
        chk("first_issue", issue_vld, 1);
        chk("first_busy", busy, 1);
      end
      chk("stage_done", stage_done, pe);
      if (stall) begin
        st++;
        chk("stall_issue", issue_vld, 0);
        chk("stall_hold", {stage_num, bfly_idx, m0_s, m1_s, m2_s, m3_s, tw_addr}, {4'd2, 4'd7, 1'b1, 2'd1, 1'b0, 1'b0, 4'd12});
      end
      pe = issue_vld && bfly_idx == 4'd15;
      if (issue_vld) begin
        chk("issue_stage", stage_num, n_iss / 16);
        chk("issue_bfly", bfly_idx, n_iss % 16);
        if (n_iss == 21) chk("sel_s1b5", {m0_s, m1_s, m2_s, m3_s, tw_addr}, {1'b1, 2'd1, 1'b1, 1'b0, 4'd10});
        if (n_iss == 79) chk("sel_s4b15", {m0_s, m1_s, m2_s, m3_s, tw_addr}, {1'b0, 2'd2, 1'b0, 1'b1, 4'd0});
        n_iss++;
      end else if (stall_at < 0) begin
        chk("no_bubble", n_iss, 80);
      end
      if (fft_done) begin
        chk("done_busy", busy, 0);
        dcyc = c;
        stall = 1'b0;
        start = 1'b0;
        return;
      end
    end
    chk("done_timeout", 0, 1);
  endtask

  initial begin
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    run(-1, 0, -1, -1, done_cyc, issues);
    chk("plain_issues", issues, 80);
    chk("plain_done", done_cyc, 84);
    run(39, 3, -1, -1, done_cyc, issues);
    chk("stall_issues", issues, 80);
    chk("stall_done", done_cyc, 87);
    run(-1, 0, 50, -1, done_cyc, issues);
    chk("busy_start_issues", issues, 80);
    chk("busy_start_done", done_cyc, 84);
    run(-1, 0, -1, -1, done_cyc, issues);
    chk("b2b_issues", issues, 80);
    chk("b2b_done", done_cyc, 84);
    run(-1, 0, -1, 41, done_cyc, issues);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_quiet", {busy, stage_done, fft_done}, 0);
    end
    run(-1, 0, -1, -1, done_cyc, issues);
    chk("post_rst_issues", issues, 80);
    chk("post_rst_done", done_cyc, 84);
    @(negedge clk);
    #1;
    start_b = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      #1;
      chk("b_issue", issue_vld_b, c <= 12);
      if (c <= 12) chk("b_idx", {stage_num_b, bfly_idx_b}, {4'((c - 1) / 4), 2'((c - 1) % 4)});
      chk("b_stage_done", stage_done_b, c == 5 || c == 9 || c == 13);
      chk("b_fft_done", fft_done_b, c == 13);
      chk("b_busy", busy_b, c <= 12);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
